// File: rtl/hazard_forward_unit.sv
// Pipeline hazard controller: shadows E/M/W destination metadata, produces the
// execute-stage forward selectors and the fetch/decode/execute stall and flush controls.
module hazard_forward_unit #(
    parameter int REG_BITS    = 4,
    parameter bit ZERO_REG_EN = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_BITS-1:0] ra1D,
    input  logic [REG_BITS-1:0] ra2D,
    input  logic [REG_BITS-1:0] waD,
    input  logic                regWriteD,
    input  logic                memToRegD,
    input  logic                branchTakenE,
    output logic [1:0]          data1ForwardSelector,
    output logic [1:0]          data2ForwardSelector,
    output logic                stallF,
    output logic                stallD,
    output logic                flushD,
    output logic                flushE
);

    logic [REG_BITS-1:0] ra1E_q, ra1E_d, ra2E_q, ra2E_d, waE_q, waE_d;
    logic                regWriteE_q, regWriteE_d, memToRegE_q, memToRegE_d;
    logic [REG_BITS-1:0] waM_q, waM_d, waW_q, waW_d;
    logic                regWriteM_q, regWriteM_d, memToRegM_q, memToRegM_d;
    logic                regWriteW_q, regWriteW_d;

    logic lw_stall_e, lw_stall_m, lw_stall, flush_e_int;
    logic [1:0] sel1, sel2;

    // Index 0 is never a real dependency when it is hardwired to zero.
    function automatic logic live(input logic [REG_BITS-1:0] r);
        return !(ZERO_REG_EN && (r == '0));
    endfunction

    // A load sitting in M cannot forward yet, so M only wins for ALU results.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_BITS-1:0] ras,
        input logic                rw_m,
        input logic                mtr_m,
        input logic [REG_BITS-1:0] wa_m,
        input logic                rw_w,
        input logic [REG_BITS-1:0] wa_w
    );
        if (rw_m && !mtr_m && (wa_m == ras) && live(ras)) begin
            return 2'b10;
        end else if (rw_w && (wa_w == ras) && live(ras)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        sel1 = fwd_sel(ra1E_q, regWriteM_q, memToRegM_q, waM_q, regWriteW_q, waW_q);
        sel2 = fwd_sel(ra2E_q, regWriteM_q, memToRegM_q, waM_q, regWriteW_q, waW_q);

        // Load in E or still in M: its data is not available to a decode-stage consumer.
        lw_stall_e = memToRegE_q && regWriteE_q &&
                     (((waE_q == ra1D) && live(ra1D)) || ((waE_q == ra2D) && live(ra2D)));
        lw_stall_m = memToRegM_q && regWriteM_q &&
                     (((waM_q == ra1D) && live(ra1D)) || ((waM_q == ra2D) && live(ra2D)));
        lw_stall    = lw_stall_e || lw_stall_m;
        flush_e_int = lw_stall || branchTakenE;
    end

    always_comb begin
        ra1E_d      = flush_e_int ? '0   : ra1D;
        ra2E_d      = flush_e_int ? '0   : ra2D;
        waE_d       = flush_e_int ? '0   : waD;
        regWriteE_d = flush_e_int ? 1'b0 : regWriteD;
        memToRegE_d = flush_e_int ? 1'b0 : memToRegD;
        waM_d       = waE_q;
        regWriteM_d = regWriteE_q;
        memToRegM_d = memToRegE_q;
        waW_d       = waM_q;
        regWriteW_d = regWriteM_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra1E_q      <= '0;
            ra2E_q      <= '0;
            waE_q       <= '0;
            regWriteE_q <= 1'b0;
            memToRegE_q <= 1'b0;
            waM_q       <= '0;
            regWriteM_q <= 1'b0;
            memToRegM_q <= 1'b0;
            waW_q       <= '0;
            regWriteW_q <= 1'b0;
        end else begin
            ra1E_q      <= ra1E_d;
            ra2E_q      <= ra2E_d;
            waE_q       <= waE_d;
            regWriteE_q <= regWriteE_d;
            memToRegE_q <= memToRegE_d;
            waM_q       <= waM_d;
            regWriteM_q <= regWriteM_d;
            memToRegM_q <= memToRegM_d;
            waW_q       <= waW_d;
            regWriteW_q <= regWriteW_d;
        end
    end

    // Branch redirect dominates a simultaneous load-use stall; reset silences everything.
    assign data1ForwardSelector = rst ? 2'b00 : sel1;
    assign data2ForwardSelector = rst ? 2'b00 : sel2;
    assign stallF               = !rst && lw_stall && !branchTakenE;
    assign stallD               = !rst && lw_stall && !branchTakenE;
    assign flushD               = !rst && branchTakenE;
    assign flushE               = !rst && flush_e_int;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: one instance with index 0 as a normal register and one
// with it hardwired to zero, both driven by the same per-cycle decode-stage vectors.
module tb_hazard_forward_unit;

    localparam int          PULSE_AT = 27;
    localparam logic [7:0]  Z        = 8'b0000_0000;
    localparam logic [7:0]  STALL    = 8'b0000_1101;
    localparam logic [7:0]  BR       = 8'b0000_0011;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ra1D, ra2D, waD;
    logic       regWriteD, memToRegD, branchTakenE;

    logic [1:0] s1_0, s2_0, s1_1, s2_1;
    logic       sf0, sd0, fd0, fe0, sf1, sd1, fd1, fe1;
    logic [7:0] out0, out1;

    typedef struct {
        logic       r;
        logic [3:0] a1, a2, w;
        logic       rw, mtr, br;
        logic [7:0] e0, e1;
    } vec_t;

    vec_t       vec_q[$];
    logic [7:0] exp_q[$];
    int         n_pass  = 0;
    int         n_total = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_BITS(4), .ZERO_REG_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .ra1D(ra1D), .ra2D(ra2D), .waD(waD),
        .regWriteD(regWriteD), .memToRegD(memToRegD), .branchTakenE(branchTakenE),
        .data1ForwardSelector(s1_0), .data2ForwardSelector(s2_0),
        .stallF(sf0), .stallD(sd0), .flushD(fd0), .flushE(fe0)
    );

    hazard_forward_unit #(.REG_BITS(4), .ZERO_REG_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .ra1D(ra1D), .ra2D(ra2D), .waD(waD),
        .regWriteD(regWriteD), .memToRegD(memToRegD), .branchTakenE(branchTakenE),
        .data1ForwardSelector(s1_1), .data2ForwardSelector(s2_1),
        .stallF(sf1), .stallD(sd1), .flushD(fd1), .flushE(fe1)
    );

    assign out0 = {s1_0, s2_0, sf0, sd0, fd0, fe0};
    assign out1 = {s1_1, s2_1, sf1, sd1, fd1, fe1};

    task automatic add(input logic r, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [3:0] w, input logic rw, input logic mtr,
                       input logic br, input logic [7:0] e0, input logic [7:0] e1);
        vec_t v;
        v.r = r; v.a1 = a1; v.a2 = a2; v.w = w;
        v.rw = rw; v.mtr = mtr; v.br = br; v.e0 = e0; v.e1 = e1;
        vec_q.push_back(v);
    endtask

    // Output word is {sel1, sel2, stallF, stallD, flushD, flushE}.
    task automatic check(input string name, input int idx, input logic [7:0] act);
        logic [7:0] exp;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s[%0d]: got %b, no expected value queued", name, idx, act);
            return;
        end
        exp = exp_q.pop_front();
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %b required %b", name, idx, act, exp);
    endtask

    initial begin
        rst = 1'b1;
        ra1D = '0; ra2D = '0; waD = '0;
        regWriteD = 1'b0; memToRegD = 1'b0; branchTakenE = 1'b0;

        //   r  a1  a2  w  rw mtr br  dut0          dut1
        add(1,  3,  3,  3, 1, 0, 0, Z,            Z);            // 0  reset held, writer r3 on D
        add(1,  3,  3,  3, 1, 0, 0, Z,            Z);            // 1
        add(0,  3,  3,  3, 1, 0, 0, Z,            Z);            // 2  first cycle after release
        add(0,  9,  9,  9, 0, 0, 0, Z,            Z);            // 3
        add(0,  1,  1,  5, 1, 0, 0, Z,            Z);            // 4  writer r5
        add(0,  5,  5,  6, 1, 0, 0, Z,            Z);            // 5  consumer A of r5
        add(0,  5,  8,  7, 1, 0, 0, 8'b1010_0000, 8'b1010_0000); // 6  A in E, r5 from M
        add(0,  9,  9,  9, 0, 0, 0, 8'b0100_0000, 8'b0100_0000); // 7  B in E, r5 from W
        add(0,  9,  9,  2, 1, 0, 0, Z,            Z);            // 8  writer r2
        add(0,  9,  9,  2, 1, 0, 0, Z,            Z);            // 9  writer r2 again
        add(0,  9,  2, 10, 1, 0, 0, Z,            Z);            // 10 consumer of r2
        add(0,  9,  9,  9, 0, 0, 0, 8'b0010_0000, 8'b0010_0000); // 11 youngest r2 (M) wins
        add(0,  9,  9,  4, 1, 1, 0, Z,            Z);            // 12 load r4
        add(0,  4,  9, 11, 1, 0, 0, STALL,        STALL);        // 13 load in E
        add(0,  4,  9, 11, 1, 0, 0, STALL,        STALL);        // 14 load in M
        add(0,  4,  9, 11, 1, 0, 0, Z,            Z);            // 15 stall released
        add(0,  9,  9,  9, 0, 0, 0, Z,            Z);            // 16
        add(0,  9,  9, 12, 1, 1, 0, Z,            Z);            // 17 load r12
        add(0, 12, 12, 13, 1, 0, 1, BR,           BR);           // 18 load-use with taken branch
        add(0,  9,  9,  9, 0, 0, 0, Z,            Z);            // 19
        add(0,  9,  9,  9, 0, 0, 1, BR,           BR);           // 20 branch alone
        add(0,  9,  9,  9, 0, 0, 0, Z,            Z);            // 21
        add(0,  9,  9,  0, 1, 0, 0, Z,            Z);            // 22 writer r0
        add(0,  0,  9, 14, 1, 0, 0, Z,            Z);            // 23 reader of r0 (src1)
        add(0,  9,  0, 14, 1, 0, 0, 8'b1000_0000, Z);            // 24 r0 from M only if real
        add(0,  9,  9,  0, 1, 1, 0, 8'b0001_0000, Z);            // 25 r0 from W; load r0 on D
        add(0,  0,  0, 15, 1, 0, 0, STALL,        Z);            // 26 load r0 in E
        add(0,  0,  0, 15, 1, 0, 0, STALL,        Z);            // 27 load r0 in M, then rst pulse
        add(1,  9,  9,  9, 0, 0, 0, Z,            Z);            // 28 reset still held
        add(0,  9,  9,  5, 1, 0, 0, Z,            Z);            // 29 restart: writer r5
        add(0,  5,  5,  6, 1, 0, 0, Z,            Z);            // 30 consumer
        add(0,  9,  9,  9, 0, 0, 0, 8'b1010_0000, 8'b1010_0000); // 31 forwarding after restart

        for (int i = 0; i < vec_q.size(); i++) begin
            @(negedge clk);
            rst          = vec_q[i].r;
            ra1D         = vec_q[i].a1;
            ra2D         = vec_q[i].a2;
            waD          = vec_q[i].w;
            regWriteD    = vec_q[i].rw;
            memToRegD    = vec_q[i].mtr;
            branchTakenE = vec_q[i].br;
            exp_q.push_back(vec_q[i].e0);
            exp_q.push_back(vec_q[i].e1);
            #2;
            check("vec_dut0", i, out0);
            check("vec_dut1", i, out1);
            if (i == PULSE_AT) begin
                // Asynchronous reset in the middle of the stall cycle, no clock edge in between.
                rst = 1'b1;
                exp_q.push_back(Z);
                exp_q.push_back(Z);
                #1;
                check("rst_mid_dut0", i, out0);
                check("rst_mid_dut1", i, out1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
